sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares one single-port 32-bit SRAM macro between the AHB SRAM bridge (port A) and a
//  secondary requester (port B: DMA/loader) with a req/gnt handshake. Port A cannot be
//  stalled (its HREADYOUT is tied high), so it always has absolute priority and port B
//  uses idle SRAM cycles. An INIT FSM zero-fills the macro after reset or on request.
//  Starved port-B requests raise a flag.
// PARAMETERS
//  AW          9    word-address width (depth = 2**AW words)
//  INIT_EN     1    1: zero-fill after reset; 0: enter RUN directly
//  SW          8    starvation-counter width
//  STARVE_MAX  200  wait cycles before b_starve asserts (must be < 2**SW)
// PORTS
//  HCLK        in   1   system clock
//  HRESETn     in   1   async active-low reset
//  a_cs        in   1   port A chip select (from AHB SRAM bridge)
//  a_wen       in   4   port A byte write enables
//  a_addr      in   AW  port A word address
//  a_wdata     in   32  port A write data
//  a_rdata     out  32  port A read data (data phase)
//  b_req       in   1   port B request; held with b_addr/b_we/b_wdata until b_gnt
//  b_we        in   4   port B byte write enables (0 = read)
//  b_addr      in   AW  port B word address
//  b_wdata     in   32  port B write data
//  b_gnt       out  1   port B grant (same cycle as the SRAM access)
//  b_rvalid    out  1   port B read data valid
//  b_rdata     out  32  port B read data
//  b_starve    out  1   port B request waiting >= STARVE_MAX cycles
//  init_req    in   1   pulse: restart zero-fill (honoured in RUN only)
//  init_busy   out  1   zero-fill in progress
//  a_drop_err  out  1   sticky: port A access arrived during INIT
//  ram_cs      out  1   SRAM chip select
//  ram_wen     out  4   SRAM byte write enables
//  ram_addr    out  AW  SRAM address
//  ram_wdata   out  32  SRAM write data
//  ram_rdata   in   32  SRAM read data (valid 1 cycle after a read select)
// BEHAVIOUR
//  - States: INIT, RUN. Reset -> INIT if INIT_EN else RUN.
//  - Reset values: init_cnt=0, b_rvalid=0, starve_cnt=0, a_drop_err=0,
//    init_busy=INIT_EN; all other outputs are combinational.
//  - INIT: ram_cs=1, ram_wen=4'hF, ram_addr=init_cnt, ram_wdata=0, init_cnt+1 per cycle.
//    At init_cnt==2**AW-1, write that word and go to RUN. Takes 2**AW cycles.
//    init_cnt returns to 0.
//  - INIT side rules: b_gnt=0; starve_cnt held at 0; a_cs=1 sets a_drop_err.
//    The port A access is dropped: no write, and a_rdata is undefined.
//  - RUN: if a_cs, pass port A through to ram_* and hold b_gnt=0.
//    Else b_gnt=b_req, and port B drives ram_* with ram_cs=b_req.
//  - a_rdata = ram_rdata always (combinational).
//  - b_rvalid is registered: set the cycle after b_req & b_gnt & (b_we==0), else 0.
//  - b_rdata = ram_rdata (combinational); meaningful only when b_rvalid=1.
//  - Simultaneous a_cs and b_req: A wins; B waits with no data loss.
//  - starve_cnt (RUN): +1 per cycle with b_req & ~b_gnt, saturating at 2**SW-1.
//    Cleared on b_gnt or when b_req=0. b_starve = (starve_cnt >= STARVE_MAX).
//  - init_req in RUN -> INIT on next edge. Same-cycle port A/B accesses still complete.
//    A port B read granted that cycle still returns b_rvalid in the first INIT cycle.
//  - init_req during INIT is ignored (no restart).
//  - Reset mid-INIT restarts the fill from word 0.
//  - Port B write hazard is not tracked: the issuer orders reads after its own writes.
// TESTING
//  - Reset with INIT_EN=1, AW=4: 16 cycles of ram_wen=F, addr 0..15, wdata 0.
//    init_busy then falls and the state is RUN.
//  - RUN, b_req=1, b_we=0, b_addr=5, a_cs=0: b_gnt=1 the same cycle.
//    Next cycle b_rvalid=1 with b_rdata = macro word 5.
//  - a_cs=1 held 3 cycles with b_req=1 write to addr 7: b_gnt=0 for those 3 cycles.
//    Grant in cycle 4; macro word 7 updated.
//  - STARVE_MAX=3, a_cs=1 continuous, b_req=1: b_starve rises after 3 wait cycles.
//    It falls the cycle after b_gnt.
//  - a_cs=1 during INIT: a_drop_err=1 and stays set through RUN until HRESETn low.
//  - init_req in RUN with a concurrent port B read: read completes (b_rvalid next cycle).
//    Fill then starts at word 0 and init_busy=1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port 32-bit SRAM between port A (AHB bridge, never stalled) and port B (req/gnt).
// Port A (a_cs/a_wen/a_addr/a_wdata/a_rdata) always has priority and cannot be held off.
// Port B (b_req/b_we/b_addr/b_wdata -> b_gnt/b_rvalid/b_rdata/b_starve) uses the idle SRAM cycles.
// init_req/init_busy control the zero-fill; a_drop_err flags port A accesses lost during the fill.
// ram_cs/ram_wen/ram_addr/ram_wdata/ram_rdata connect to the SRAM macro (1-cycle read latency).
module sram_port_arbiter #(
  parameter int AW         = 9,
  parameter bit INIT_EN    = 1'b1,
  parameter int SW         = 8,
  parameter int STARVE_MAX = 200
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          a_cs,
  input  logic [3:0]    a_wen,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_req,
  input  logic [3:0]    b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          b_starve,
  input  logic          init_req,
  output logic          init_busy,
  output logic          a_drop_err,
  output logic          ram_cs,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] init_cnt;
  logic [SW-1:0] starve_cnt;
  logic run;
  assign run       = state_q == RUN;
  assign init_busy = ~run;
  assign a_rdata   = ram_rdata;
  assign b_rdata   = ram_rdata;
  assign b_starve  = starve_cnt >= SW'(STARVE_MAX);
  always_comb begin
    state_d   = run ? (init_req ? INIT : RUN) : (&init_cnt ? RUN : INIT);
    b_gnt     = run & ~a_cs & b_req;
    ram_cs    = run ? (a_cs | b_req) : 1'b1;
    ram_wen   = run ? (a_cs ? a_wen : b_we) : 4'hF;
    ram_addr  = run ? (a_cs ? a_addr : b_addr) : init_cnt;
    ram_wdata = run ? (a_cs ? a_wdata : b_wdata) : 32'h0;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= INIT_EN ? INIT : RUN;
      init_cnt   <= '0;
      b_rvalid   <= 1'b0;
      starve_cnt <= '0;
      a_drop_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt   <= run ? '0 : init_cnt + 1'b1;
      b_rvalid   <= b_gnt & ~|b_we;
      starve_cnt <= (!run || !b_req || b_gnt) ? '0 : (&starve_cnt ? starve_cnt : starve_cnt + 1'b1);
      a_drop_err <= a_drop_err | (~run & a_cs);
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench for sram_port_arbiter with a behavioural SRAM macro.
module tb_sram_port_arbiter;
  localparam int AW = 4;
  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          a_cs = 1'b0;
  logic [3:0]    a_wen = 4'h0;
  logic [AW-1:0] a_addr = '0;
  logic [31:0]   a_wdata = '0;
  logic [31:0]   a_rdata;
  logic          b_req = 1'b0;
  logic [3:0]    b_we = 4'h0;
  logic [AW-1:0] b_addr = '0;
  logic [31:0]   b_wdata = '0;
  logic          b_gnt, b_rvalid, b_starve, init_busy, a_drop_err;
  logic [31:0]   b_rdata;
  logic          init_req = 1'b0;
  logic          ram_cs;
  logic [3:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   mem [0:15];
  logic [31:0]   shadow [0:15];
  logic [31:0]   sb [$];
  logic [31:0]   exp_d;
  int total = 0;
  int bad = 0;

  sram_port_arbiter #(.AW(AW), .INIT_EN(1'b1), .SW(8), .STARVE_MAX(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .a_cs(a_cs), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_starve(b_starve),
    .init_req(init_req), .init_busy(init_busy), .a_drop_err(a_drop_err),
    .ram_cs(ram_cs), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (ram_cs) begin
      for (int k = 0; k < 4; k++)
        if (ram_wen[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
      if (ram_wen == 4'h0) ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (b_rvalid) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL sb_underflow got b_rdata=%h exp=no pending read", b_rdata);
        end else begin
          exp_d = sb.pop_front();
          if (b_rdata !== exp_d) begin bad++; $display("FAIL b_rdata got=%h exp=%h", b_rdata, exp_d); end
        end
      end
      if (b_req && b_gnt) begin
        if (b_we == 4'h0) sb.push_back(shadow[b_addr]);
        else for (int k = 0; k < 4; k++) if (b_we[k]) shadow[b_addr][8*k +: 8] = b_wdata[8*k +: 8];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge HCLK); #1;
  endtask

  task automatic sample();
    @(negedge HCLK); #1;
  endtask

  task automatic test_reset();
    sample();
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL rst_init_busy got=%b exp=1", init_busy); end
    total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL rst_b_rvalid got=%b exp=0", b_rvalid); end
    total++; if (a_drop_err !== 1'b0) begin bad++; $display("FAIL rst_a_drop_err got=%b exp=0", a_drop_err); end
    total++; if (b_starve !== 1'b0) begin bad++; $display("FAIL rst_b_starve got=%b exp=0", b_starve); end
    total++; if (ram_addr !== 4'd0) begin bad++; $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); end
  endtask

  task automatic test_init();
    step(); HRESETn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      sample();
      total++; if ({ram_cs, ram_wen} !== 5'h1F) begin bad++; $display("FAIL init_cs_wen[%0d] got=%b/%h exp=1/f", i, ram_cs, ram_wen); end
      total++; if (ram_addr !== 4'(i)) begin bad++; $display("FAIL init_addr got=%0d exp=%0d", ram_addr, i); end
      total++; if (ram_wdata !== 32'h0) begin bad++; $display("FAIL init_wdata got=%h exp=0", ram_wdata); end
      total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL init_busy[%0d] got=%b exp=1", i, init_busy); end
    end
    step(); sample();
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL init_done got=%b exp=0", init_busy); end
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
  endtask

  task automatic test_b_read();
    step(); b_req = 1'b1; b_we = 4'hF; b_addr = 4'd5; b_wdata = 32'h12345678;
    sample();
    total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL bw_gnt got=%b exp=1", b_gnt); end
    total++; if ({ram_wen, ram_addr} !== {4'hF, 4'd5}) begin bad++; $display("FAIL bw_ram got=%h/%0d exp=f/5", ram_wen, ram_addr); end
    step(); b_we = 4'h0;
    sample();
    total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL br_gnt got=%b exp=1", b_gnt); end
    step(); b_req = 1'b0;
    sample();
    total++; if (b_rvalid !== 1'b1) begin bad++; $display("FAIL br_rvalid got=%b exp=1", b_rvalid); end
    step(); sample();
    total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL br_rvalid_clr got=%b exp=0", b_rvalid); end
  endtask

  task automatic test_a_path();
    step(); a_cs = 1'b1; a_wen = 4'h3; a_addr = 4'd2; a_wdata = 32'hAABBCCDD;
    sample();
    total++; if ({ram_cs, ram_wen, ram_addr} !== {1'b1, 4'h3, 4'd2}) begin bad++; $display("FAIL aw_ram got=%b/%h/%0d exp=1/3/2", ram_cs, ram_wen, ram_addr); end
    total++; if (ram_wdata !== 32'hAABBCCDD) begin bad++; $display("FAIL aw_wdata got=%h exp=aabbccdd", ram_wdata); end
    shadow[2] = 32'h0000CCDD;
    step(); a_wen = 4'h0;
    sample();
    step(); a_cs = 1'b0;
    sample();
    total++; if (a_rdata !== 32'h0000CCDD) begin bad++; $display("FAIL a_rdata got=%h exp=0000ccdd", a_rdata); end
  endtask

  task automatic test_a_priority();
    step(); a_cs = 1'b1; a_wen = 4'h0; a_addr = 4'd5;
    b_req = 1'b1; b_we = 4'hF; b_addr = 4'd7; b_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      sample();
      total++; if (b_gnt !== 1'b0) begin bad++; $display("FAIL prio_gnt[%0d] got=%b exp=0", k, b_gnt); end
      total++; if (ram_addr !== 4'd5) begin bad++; $display("FAIL prio_addr[%0d] got=%0d exp=5", k, ram_addr); end
      if (k > 0) begin
        total++; if (a_rdata !== 32'h12345678) begin bad++; $display("FAIL prio_a_rdata got=%h exp=12345678", a_rdata); end
      end
      step();
    end
    a_cs = 1'b0;
    sample();
    total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL prio_gnt4 got=%b exp=1", b_gnt); end
    total++; if (ram_addr !== 4'd7) begin bad++; $display("FAIL prio_addr4 got=%0d exp=7", ram_addr); end
    step(); b_req = 1'b0;
    sample();
    total++; if (mem[7] !== 32'hCAFEF00D) begin bad++; $display("FAIL prio_mem7 got=%h exp=cafef00d", mem[7]); end
  endtask

  task automatic test_starve();
    step(); a_cs = 1'b1; a_wen = 4'h0; a_addr = 4'd0;
    b_req = 1'b1; b_we = 4'h0; b_addr = 4'd7;
    for (int k = 0; k < 6; k++) begin
      sample();
      total++; if (b_starve !== (k >= 3)) begin bad++; $display("FAIL starve[%0d] got=%b exp=%b", k, b_starve, k >= 3); end
      total++; if (b_gnt !== 1'b0) begin bad++; $display("FAIL starve_gnt[%0d] got=%b exp=0", k, b_gnt); end
      step();
    end
    a_cs = 1'b0;
    sample();
    total++; if ({b_gnt, b_starve} !== 2'b11) begin bad++; $display("FAIL starve_gnt_cycle got=%b exp=11", {b_gnt, b_starve}); end
    step(); b_req = 1'b0;
    sample();
    total++; if (b_starve !== 1'b0) begin bad++; $display("FAIL starve_fall got=%b exp=0", b_starve); end
    total++; if (b_rvalid !== 1'b1) begin bad++; $display("FAIL starve_rvalid got=%b exp=1", b_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    addrs = '{4'd2, 4'd7, 4'd5};
    for (int k = 0; k < 3; k++) begin
      step(); b_req = 1'b1; b_we = 4'h0; b_addr = addrs[k];
      sample();
      total++; if (b_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b exp=1", k, b_gnt); end
      total++; if (b_rvalid !== (k > 0)) begin bad++; $display("FAIL b2b_rvalid[%0d] got=%b exp=%b", k, b_rvalid, k > 0); end
    end
    step(); b_req = 1'b0;
    sample();
    total++; if (b_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b exp=1", b_rvalid); end
  endtask

  task automatic test_init_req();
    step(); b_req = 1'b1; b_we = 4'h0; b_addr = 4'd7; init_req = 1'b1;
    sample();
    total++; if ({b_gnt, init_busy} !== 2'b10) begin bad++; $display("FAIL ireq_gnt_busy got=%b exp=10", {b_gnt, init_busy}); end
    step(); init_req = 1'b0; b_req = 1'b0;
    a_cs = 1'b1; a_wen = 4'hF; a_addr = 4'd3; a_wdata = 32'hFFFFFFFF;
    sample();
    total++; if ({init_busy, b_rvalid} !== 2'b11) begin bad++; $display("FAIL ireq_busy_rvalid got=%b exp=11", {init_busy, b_rvalid}); end
    total++; if ({ram_wen, ram_addr, ram_wdata} !== {4'hF, 4'd0, 32'h0}) begin bad++; $display("FAIL ireq_fill0 got=%h/%0d/%h exp=f/0/0", ram_wen, ram_addr, ram_wdata); end
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    step(); a_cs = 1'b0; init_req = 1'b1; b_req = 1'b1; b_we = 4'h0; b_addr = 4'd7;
    sample();
    total++; if (a_drop_err !== 1'b1) begin bad++; $display("FAIL drop_err_set got=%b exp=1", a_drop_err); end
    total++; if ({ram_addr, b_gnt} !== {4'd1, 1'b0}) begin bad++; $display("FAIL ireq_fill1 got=%0d/%b exp=1/0", ram_addr, b_gnt); end
    step(); init_req = 1'b0;
    sample();
    total++; if (ram_addr !== 4'd2) begin bad++; $display("FAIL ireq_no_restart got=%0d exp=2", ram_addr); end
    total++; if ({b_gnt, b_starve} !== 2'b00) begin bad++; $display("FAIL ireq_init_b got=%b exp=00", {b_gnt, b_starve}); end
    for (int i = 3; i < 16; i++) begin
      step(); sample();
      total++; if (ram_addr !== 4'(i)) begin bad++; $display("FAIL ireq_fill got=%0d exp=%0d", ram_addr, i); end
    end
    step(); sample();
    total++; if ({init_busy, b_gnt} !== 2'b01) begin bad++; $display("FAIL ireq_run got=%b exp=01", {init_busy, b_gnt}); end
    step(); b_req = 1'b0;
    sample();
    total++; if ({b_rvalid, a_drop_err} !== 2'b11) begin bad++; $display("FAIL ireq_sticky got=%b exp=11", {b_rvalid, a_drop_err}); end
    total++; if (mem[3] !== 32'h0) begin bad++; $display("FAIL ireq_mem3 got=%h exp=0", mem[3]); end
  endtask

  task automatic test_reset_mid_init();
    step(); HRESETn = 1'b0;
    sample();
    total++; if ({a_drop_err, init_busy} !== 2'b01) begin bad++; $display("FAIL mid_rst got=%b exp=01", {a_drop_err, init_busy}); end
    step(); HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); sample(); end
    total++; if (ram_addr !== 4'd5) begin bad++; $display("FAIL mid_progress got=%0d exp=5", ram_addr); end
    step(); HRESETn = 1'b0;
    step(); HRESETn = 1'b1;
    sample();
    total++; if (ram_addr !== 4'd0) begin bad++; $display("FAIL mid_restart got=%0d exp=0", ram_addr); end
    for (int i = 1; i < 16; i++) step();
    step(); sample();
    total++; if ({init_busy, a_drop_err} !== 2'b00) begin bad++; $display("FAIL mid_done got=%b exp=00", {init_busy, a_drop_err}); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_b_read();
    test_a_path();
    test_a_priority();
    test_starve();
    test_back_to_back();
    test_init_req();
    test_reset_mid_init();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
